// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the Pong datapath.
//   - state_e      : game-flow state encoding (3 bits)
//   - frame/ball geometry constants used as parameter defaults
//   - ball_right_edge: right-most pixel column of the ball, no wrap
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_POINT     = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_e;

  localparam int FRAME_WIDTH  = 640;
  localparam int FRAME_HEIGHT = 480;
  localparam int BALL_SIZE_PX = 10;
  localparam int LEFT_GOAL_X  = 2;
  localparam int RIGHT_GOAL_X = 637;

  // Widened to 13 bits so a ball near x=4095 cannot wrap back to the left.
  function automatic logic [12:0] ball_right_edge(input logic [11:0] x, input int size);
    return {1'b0, x} + 13'(size) - 13'd1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: single-register rising-edge detector for a debounced level.
//   clk      in  : clock
//   reset    in  : asynchronous active-high reset (previous sample -> 0)
//   in_level in  : level input
//   rise     out : high for the cycle in which in_level is 1 and was 0
// Because the previous sample resets to 0, a level already high at reset
// release yields an edge on the first clock.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in_level,
  output logic rise
);

  logic prev_q;

  // Previous-sample register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= in_level;
    end
  end

  assign rise = in_level & ~prev_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-flow controller for the Pong datapath.
//   CLOCK_25   in  : system clock
//   reset      in  : asynchronous active-high reset
//   tick       in  : one-cycle ball-update strobe (countdown time base)
//   start      in  : start/restart button level
//   pause      in  : pause toggle button level
//   ball_x_pos in  : ball left-edge x
//   ball_run   out : ball may move
//   ball_reset out : hold ball at its initial position
//   serve_left out : next serve travels left
//   score_1/2  out : player scores
//   winner     out : 0 = player 1, 1 = player 2 (valid in GAME_OVER)
//   game_over  out : high in GAME_OVER
//   state      out : current state encoding
// All outputs are registered; output values are decoded from the next state.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 90,
  parameter int LEFT_GOAL   = LEFT_GOAL_X,
  parameter int RIGHT_GOAL  = RIGHT_GOAL_X,
  parameter int BALL_SIZE   = BALL_SIZE_PX
) (
  input  logic        CLOCK_25,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        pause,
  input  logic [11:0] ball_x_pos,
  output logic        ball_run,
  output logic        ball_reset,
  output logic        serve_left,
  output logic [3:0]  score_1,
  output logic [3:0]  score_2,
  output logic        winner,
  output logic        game_over,
  output logic [2:0]  state
);

  logic start_rise;
  logic pause_rise;

  rise_detect u_start_rise (
    .clk      (CLOCK_25),
    .reset    (reset),
    .in_level (start),
    .rise     (start_rise)
  );

  rise_detect u_pause_rise (
    .clk      (CLOCK_25),
    .reset    (reset),
    .in_level (pause),
    .rise     (pause_rise)
  );

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  score_1_q, score_1_d;
  logic [3:0]  score_2_q, score_2_d;
  logic        serve_left_q, serve_left_d;
  logic        winner_q, winner_d;
  logic        ball_run_q, ball_run_d;
  logic        ball_reset_q, ball_reset_d;
  logic        game_over_q, game_over_d;

  logic        left_miss;
  logic        right_miss;
  logic [3:0]  score_1_inc;
  logic [3:0]  score_2_inc;

  assign left_miss   = ({1'b0, ball_x_pos} <= 13'(LEFT_GOAL));
  assign right_miss  = (ball_right_edge(ball_x_pos, BALL_SIZE) >= 13'(RIGHT_GOAL));
  assign score_1_inc = score_1_q + 4'd1;
  assign score_2_inc = score_2_q + 4'd1;

  // Next-state, countdown, score and output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    score_1_d    = score_1_q;
    score_2_d    = score_2_q;
    serve_left_d = serve_left_q;
    winner_d     = winner_q;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_rise) begin
          score_1_d    = 4'd0;
          score_2_d    = 4'd0;
          serve_left_d = 1'b0;
          cnt_d        = 8'(SERVE_TICKS);
          state_d      = ST_SERVE;
        end else begin
          state_d = state_q;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          if (cnt_q == 8'd0) begin
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_PLAY: begin
        // Left miss wins over right miss; any miss wins over a pause edge.
        if (left_miss) begin
          score_2_d    = score_2_inc;
          serve_left_d = 1'b1;
          if (score_2_inc == 4'(WIN_SCORE)) begin
            winner_d = 1'b1;
            state_d  = ST_GAME_OVER;
          end else begin
            cnt_d   = 8'(POINT_TICKS);
            state_d = ST_POINT;
          end
        end else if (right_miss) begin
          score_1_d    = score_1_inc;
          serve_left_d = 1'b0;
          if (score_1_inc == 4'(WIN_SCORE)) begin
            winner_d = 1'b0;
            state_d  = ST_GAME_OVER;
          end else begin
            cnt_d   = 8'(POINT_TICKS);
            state_d = ST_POINT;
          end
        end else if (pause_rise) begin
          state_d = ST_PAUSED;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PAUSED: begin
        if (pause_rise) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_POINT: begin
        if (tick) begin
          if (cnt_q == 8'd0) begin
            cnt_d   = 8'(SERVE_TICKS);
            state_d = ST_SERVE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ball_run_d   = (state_d == ST_PLAY);
    ball_reset_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) || (state_d == ST_GAME_OVER);
    game_over_d  = (state_d == ST_GAME_OVER);
  end

  // State, counter, scores and registered outputs.
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      score_1_q    <= 4'd0;
      score_2_q    <= 4'd0;
      serve_left_q <= 1'b0;
      winner_q     <= 1'b0;
      ball_run_q   <= 1'b0;
      ball_reset_q <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_1_q    <= score_1_d;
      score_2_q    <= score_2_d;
      serve_left_q <= serve_left_d;
      winner_q     <= winner_d;
      ball_run_q   <= ball_run_d;
      ball_reset_q <= ball_reset_d;
      game_over_q  <= game_over_d;
    end
  end

  assign state      = state_q;
  assign ball_run   = ball_run_q;
  assign ball_reset = ball_reset_q;
  assign serve_left = serve_left_q;
  assign score_1    = score_1_q;
  assign score_2    = score_2_q;
  assign winner     = winner_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl (SERVE_TICKS=3, POINT_TICKS=45, WIN_SCORE=7).
// Inputs change on the falling edge; outputs are sampled on the next falling edge.
module tb_pong_game_ctrl;

  localparam int ST_IDLE = 0, ST_SERVE = 1, ST_PLAY = 2, ST_PAUSED = 3, ST_POINT = 4, ST_GO = 5;

  logic        CLOCK_25;
  logic        reset;
  logic        tick;
  logic        start;
  logic        pause;
  logic [11:0] ball_x_pos;
  logic        ball_run;
  logic        ball_reset;
  logic        serve_left;
  logic [3:0]  score_1;
  logic [3:0]  score_2;
  logic        winner;
  logic        game_over;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  pong_game_ctrl #(
    .WIN_SCORE   (7),
    .SERVE_TICKS (3),
    .POINT_TICKS (45)
  ) dut (
    .CLOCK_25   (CLOCK_25),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .pause      (pause),
    .ball_x_pos (ball_x_pos),
    .ball_run   (ball_run),
    .ball_reset (ball_reset),
    .serve_left (serve_left),
    .score_1    (score_1),
    .score_2    (score_2),
    .winner     (winner),
    .game_over  (game_over),
    .state      (state)
  );

  initial CLOCK_25 = 1'b0;
  always #5 CLOCK_25 = ~CLOCK_25;

  typedef struct {
    logic        start;
    logic        pause;
    logic        tick;
    logic [11:0] x;
    int          st;
    logic        run;
    logic        rst;
    logic        sl;
    int          s1;
    int          s2;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Full output check; game_over is implied by the state, winner checked only in GAME_OVER.
  task automatic chk_all(input string tag, input int st, input logic run, input logic rst,
                         input logic sl, input int s1, input int s2, input logic win);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".ball_run"}, int'(ball_run), int'(run));
    chk({tag, ".ball_reset"}, int'(ball_reset), int'(rst));
    chk({tag, ".serve_left"}, int'(serve_left), int'(sl));
    chk({tag, ".score_1"}, int'(score_1), s1);
    chk({tag, ".score_2"}, int'(score_2), s2);
    chk({tag, ".game_over"}, int'(game_over), (st == ST_GO) ? 1 : 0);
    if (st == ST_GO) chk({tag, ".winner"}, int'(winner), int'(win));
  endtask

  task automatic cyc();
    @(negedge CLOCK_25);
  endtask

  // From POINT (cnt just loaded with 45): 46 ticks to SERVE, 4 more to PLAY.
  task automatic point_to_play(input int s1, input int s2, input logic sl);
    tick = 1'b1;
    for (int i = 0; i < 45; i++) begin
      cyc();
      chk("point_hold", int'(state), ST_POINT);
    end
    cyc();
    chk_all("point_exit", ST_SERVE, 1'b0, 1'b1, sl, s1, s2, 1'b0);
    ball_x_pos = 12'd320;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("serve_hold", int'(state), ST_SERVE);
    end
    cyc();
    chk_all("serve_exit", ST_PLAY, 1'b1, 1'b0, sl, s1, s2, 1'b0);
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; pause = 1'b0; tick = 1'b0; ball_x_pos = 12'd320;

    //          start pause tick  x       state     run   rst   sl    s1 s2
    vecs[0] = '{1'b1, 1'b0, 1'b0, 12'd320, ST_SERVE, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 12'd320, ST_SERVE, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 12'd320, ST_SERVE, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 12'd320, ST_SERVE, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 12'd320, ST_PLAY,  1'b1, 1'b0, 1'b0, 0, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 12'd3,   ST_PLAY,  1'b1, 1'b0, 1'b0, 0, 0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 12'd627, ST_PLAY,  1'b1, 1'b0, 1'b0, 0, 0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 12'd320, ST_PLAY,  1'b1, 1'b0, 1'b0, 0, 0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 12'd2,   ST_POINT, 1'b0, 1'b0, 1'b1, 0, 1};

    // Reset values while reset is held with start already high.
    cyc();
    chk_all("reset", ST_IDLE, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("reset.winner", int'(winner), 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      start = vecs[i].start; pause = vecs[i].pause;
      tick = vecs[i].tick; ball_x_pos = vecs[i].x;
      cyc();
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].run, vecs[i].rst, vecs[i].sl,
              vecs[i].s1, vecs[i].s2, 1'b0);
    end

    // Miss persists through POINT without effect, then back to PLAY.
    point_to_play(0, 1, 1'b1);

    // Right-edge boundary: 627 is no score, 628 scores for player 1.
    ball_x_pos = 12'd627;
    cyc();
    chk_all("x627", ST_PLAY, 1'b1, 1'b0, 1'b1, 0, 1, 1'b0);
    ball_x_pos = 12'd628;
    cyc();
    chk_all("x628", ST_POINT, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);

    for (int s = 2; s <= 6; s++) begin
      point_to_play(s - 1, 1, 1'b0);
      ball_x_pos = 12'd700;
      cyc();
      chk_all($sformatf("rmiss%0d", s), ST_POINT, 1'b0, 1'b0, 1'b0, s, 1, 1'b0);
    end
    point_to_play(6, 1, 1'b0);

    // Start pressed in PLAY is ignored and stays held into GAME_OVER.
    start = 1'b1;
    cyc();
    chk("start_in_play", int'(state), ST_PLAY);
    ball_x_pos = 12'd640;
    cyc();
    chk_all("win", ST_GO, 1'b0, 1'b1, 1'b0, 7, 1, 1'b0);
    ball_x_pos = 12'd320;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_all("go_hold", ST_GO, 1'b0, 1'b1, 1'b0, 7, 1, 1'b0);
    end
    start = 1'b0;
    cyc();
    chk("go_release", int'(state), ST_GO);
    start = 1'b1;
    cyc();
    chk_all("restart", ST_SERVE, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    start = 1'b0;
    tick = 1'b1;
    repeat (4) cyc();
    tick = 1'b0;
    chk("restart_play", int'(state), ST_PLAY);

    // Pause, ticks ignored while paused, resume.
    pause = 1'b1;
    cyc();
    chk_all("paused", ST_PAUSED, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("paused_hold", int'(state), ST_PAUSED);
    end
    tick = 1'b0; pause = 1'b0;
    cyc();
    chk("paused_release", int'(state), ST_PAUSED);
    pause = 1'b1;
    cyc();
    chk_all("resume", ST_PLAY, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    pause = 1'b0;
    cyc();
    pause = 1'b1; ball_x_pos = 12'd1;
    cyc();
    chk_all("pause_and_miss", ST_POINT, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0);
    pause = 1'b0;

    // Five ticks leave cnt at 40; reset mid-POINT is immediate.
    tick = 1'b1;
    repeat (5) cyc();
    tick = 1'b0;
    chk("pre_reset", int'(state), ST_POINT);
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", ST_IDLE, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("idle_after_reset", int'(state), ST_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
